// File: rtl/bsg_sha256_disassembler.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | bsg_sha256_disassembler: serializes one 256-bit digest into ring words,    |
// | MS word first. Optional header word: define BSG_SHA256_DISASSEMBLER_HDR_EN.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bsg_sha256_disassembler #(
  parameter int ring_width_p = 32,
  parameter int id_p         = 0
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    en_i,
  input  logic                    v_i,
  input  logic [255:0]            data_i,
  output logic                    ready_o,
  output logic                    v_o,
  output logic [ring_width_p-1:0] data_o,
  input  logic                    yumi_i
);

  localparam int N_WORDS = 256 / ring_width_p;
  localparam int CNT_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_HDR  = 2'd2
  } state_e;

`ifdef BSG_SHA256_DISASSEMBLER_HDR_EN
  localparam state_e S_FIRST = S_HDR;
  localparam logic [7:0] ID8 = 8'(id_p);
  localparam logic [7:0] N8  = 8'(N_WORDS);

  if (ring_width_p < 16) begin : g_hdr_width_chk
    $error("bsg_sha256_disassembler: ring_width_p must be >= 16 with header enabled");
  end

  logic [ring_width_p-1:0] w_hdr;
  always_comb begin
    w_hdr       = '0;
    w_hdr[15:0] = {ID8, N8};
  end
`else
  localparam state_e S_FIRST = S_SEND;
`endif

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [255:0]       digest_q, digest_d;

  // Word select by shifting the digest left so the current word lands on top.
  logic [8:0]              w_shamt;
  logic [255:0]            w_shifted;
  logic [ring_width_p-1:0] w_word;
  assign w_shamt   = 9'(cnt_q) * 9'(ring_width_p);
  assign w_shifted = digest_q << w_shamt;
  assign w_word    = w_shifted[255 -: ring_width_p];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    digest_d = digest_q;
    ready_o  = 1'b0;
    v_o      = 1'b0;
    data_o   = '0;
    if (en_i && !reset_i) begin
      case (state_q)
        S_IDLE: begin
          ready_o = 1'b1;
          if (v_i) begin
            digest_d = data_i;
            cnt_d    = '0;
            state_d  = S_FIRST;
          end
        end
`ifdef BSG_SHA256_DISASSEMBLER_HDR_EN
        S_HDR: begin
          v_o    = 1'b1;
          data_o = w_hdr;
          if (yumi_i) state_d = S_SEND;
        end
`endif
        S_SEND: begin
          v_o    = 1'b1;
          data_o = w_word;
          if (yumi_i) begin
            if (cnt_q == CNT_LAST) state_d = S_IDLE;
            else                   cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      digest_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      digest_q <= digest_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bsg_sha256_disassembler.sv
`timescale 1ns/1ps
`default_nettype none
// Testbench for bsg_sha256_disassembler: queue-of-words reference model, directed + random steps.
module tb_bsg_sha256_disassembler;

  localparam int W  = 32;
  localparam int ID = 5;
  localparam int N  = 256 / W;

  logic          clk = 1'b0;
  logic          reset_i, en_i, v_i, yumi_i;
  logic [255:0]  data_i;
  logic          ready_o, v_o;
  logic [W-1:0]  data_o;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] q[$];

  bsg_sha256_disassembler #(.ring_width_p(W), .id_p(ID)) dut (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .v_i(v_i), .data_i(data_i),
    .ready_o(ready_o), .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i)
  );

  always #5 clk = ~clk;

  localparam logic [255:0] DIG_A = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                                    32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
  localparam logic [255:0] DIG_B = {32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3,
                                    32'hE4E4E4E4, 32'hF5F5F5F5, 32'h06060606, 32'h17171717};

  function automatic logic [255:0] rand_dig();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  // Model: one accepted digest becomes a list of words; the word at the head is what must be shown.
  task automatic push_digest(input logic [255:0] d);
    logic [255:0] t;
`ifdef BSG_SHA256_DISASSEMBLER_HDR_EN
    q.push_back(W'((ID % 256) * 256 + N));
`endif
    for (int i = 0; i < N; i++) begin
      t = d >> (256 - (i + 1) * W);
      q.push_back(t[W-1:0]);
    end
  endtask

  // Called just after a negedge with inputs already applied for the coming posedge.
  task automatic tick();
    logic         e_ready, e_v;
    logic [W-1:0] e_data;
    #1;
    e_ready = en_i && !reset_i && (q.size() == 0);
    e_v     = en_i && !reset_i && (q.size() != 0);
    e_data  = e_v ? q[0] : '0;
    checks++;
    assert (ready_o === e_ready) else begin
      errors++; $error("FAIL ready_o observed=%0b expected=%0b t=%0t", ready_o, e_ready, $time);
    end
    checks++;
    assert (v_o === e_v) else begin
      errors++; $error("FAIL v_o observed=%0b expected=%0b t=%0t", v_o, e_v, $time);
    end
    checks++;
    assert (data_o === e_data) else begin
      errors++; $error("FAIL data_o observed=%h expected=%h t=%0t", data_o, e_data, $time);
    end
    if (reset_i) q.delete();
    else if (en_i) begin
      if (q.size() == 0) begin
        if (v_i) push_digest(data_i);
      end else if (yumi_i) void'(q.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic e, input logic v,
                       input logic [255:0] d, input logic y);
    reset_i = r; en_i = e; v_i = v; data_i = d; yumi_i = y;
  endtask

  initial begin
    drive(1'b1, 1'b1, 1'b0, '0, 1'b0);
    @(negedge clk);
    // Reset state
    tick(); tick();

    // Basic serialize, continuous yumi
    drive(1'b0, 1'b1, 1'b1, DIG_A, 1'b1); tick();
    v_i = 1'b0; data_i = rand_dig();
    for (int i = 0; i < 11; i++) tick();

    // Backpressure: yumi 1,0,0 pattern; v_i noise must not overwrite the digest
    drive(1'b0, 1'b1, 1'b1, DIG_A, 1'b0); tick();
    for (int i = 0; i < 30; i++) begin
      yumi_i = (i % 3 == 0); v_i = 1'b1; data_i = rand_dig();
      if (q.size() == 0) v_i = 1'b0;
      tick();
    end
    v_i = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // Back-to-back: B presented while A is in flight
    drive(1'b0, 1'b1, 1'b1, DIG_A, 1'b1); tick();
    data_i = DIG_B;
    for (int i = 0; i < 10; i++) tick();
    v_i = 1'b0;
    for (int i = 0; i < 10; i++) tick();

    // Reset mid-transfer after word 3
    drive(1'b0, 1'b1, 1'b1, DIG_A, 1'b1); tick();
    v_i = 1'b0;
`ifdef BSG_SHA256_DISASSEMBLER_HDR_EN
    tick();
`endif
    for (int i = 0; i < 3; i++) tick();
    reset_i = 1'b1; tick();
    reset_i = 1'b0; tick();
    drive(1'b0, 1'b1, 1'b1, DIG_B, 1'b1); tick();
    v_i = 1'b0;
    for (int i = 0; i < 11; i++) tick();

    // Enable freeze at cnt=4 with yumi held
    drive(1'b0, 1'b1, 1'b1, DIG_A, 1'b1); tick();
    v_i = 1'b0;
`ifdef BSG_SHA256_DISASSEMBLER_HDR_EN
    tick();
`endif
    for (int i = 0; i < 4; i++) tick();
    en_i = 1'b0; v_i = 1'b1; data_i = rand_dig();
    for (int i = 0; i < 5; i++) tick();
    en_i = 1'b1; v_i = 1'b0;
    for (int i = 0; i < 6; i++) tick();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) != 0),
            $urandom_range(0, 1) == 1, rand_dig(), $urandom_range(0, 2) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bsg_sha256_disassembler.md
# bsg_sha256_disassembler

- Return path of the SHA-256 accelerator: accepts one 256-bit digest from the SHA-256 core and serializes it onto the ring as `ring_width_p`-bit words.
- Sits between the core's digest output and the ring output port, mirroring the assembler on the input side.
- Input uses a valid/ready handshake; output uses a valid/yumi handshake.
- Holds exactly one digest at a time.

## Interface
Parameters:
- `ring_width_p`, "inv": ring word width. Must divide 256 and be at least 16. Word count N = 256/`ring_width_p`.
- `id_p`, "inv": node id. The low 8 bits are used only by the header feature.

Ports:
- `clk_i`  in  1  single clock; all state updates on rising edge.
- `reset_i`  in  1  reset, synchronous, active-high.
- `en_i`  in  1  enable; low freezes all state.
- `v_i`  in  1  digest valid from core.
- `data_i`  in  256  digest; bits [255:224] are H0.
- `ready_o`  out  1  disassembler can accept a digest.
- `v_o`  out  1  ring word valid.
- `data_o`  out  `ring_width_p`  ring word.
- `yumi_i`  in  1  consumer takes the current word; legal only while `v_o`=1.

## Operation
- Registers: state, word counter `cnt` (width clog2(N), at least 1 bit), 256-bit digest register.
- State IDLE:
  - `ready_o`=1, `v_o`=0.
  - On `v_i & ready_o`: capture `data_i`, clear `cnt`, go to SEND (or HDR when the header feature is compiled in).
- State HDR (header feature only):
  - `v_o`=1; `data_o` = zero-extended {id_p[7:0], N[7:0]}, with id in bits [15:8] and N in bits [7:0].
  - On `yumi_i`, go to SEND.
- State SEND:
  - `v_o`=1; `data_o` = digest[255-cnt*W -: W], where W = `ring_width_p`. Most-significant word is sent first.
  - On `yumi_i` with `cnt`<N-1: increment `cnt`.
  - On `yumi_i` with `cnt`=N-1: go to IDLE.
  - `cnt` never wraps past N-1.
- `en_i`=0 in any state:
  - `ready_o`=0 and `v_o`=0.
  - `v_i` and `yumi_i` are ignored.
  - State, `cnt` and the digest register hold.
- Ignored inputs:
  - `v_i` outside IDLE: no effect, and the digest register is not overwritten.
  - `yumi_i` while `v_o`=0: no effect.
- `data_o` is forced to 0 whenever `v_o`=0.

## Timing
- Reset:
  - While `reset_i`=1: `ready_o`=0, `v_o`=0, `data_o`=0.
  - The cycle after reset is released: state=IDLE, `cnt`=0, `ready_o`=1.
- Latency: first word is valid the cycle after the accept.
- Occupancy: a digest occupies N cycles (N+1 with header) under continuous `yumi_i`.
- Turnaround: `ready_o` is registered-state-only (no combinational `yumi_i`→`ready_o` path). The next accept happens no earlier than the cycle after the last `yumi_i`, giving one bubble per digest.
- Backpressure: while `v_o`=1 and `yumi_i`=0, `data_o` is stable.
- Reset mid-transfer: aborts the digest with no further words emitted. `reset_i` has priority over `en_i`, `v_i` and `yumi_i`.
- Throughput (W=32, no header): one digest per 9 cycles.

## Configuration
- Macro: `BSG_SHA256_DISASSEMBLER_HDR_EN`.
- Defined:
  - HDR state is built in; a header word precedes each digest, giving N+1 words per digest.
  - Elaboration error if `ring_width_p`<16.
- Undefined:
  - No HDR state; exactly N words per digest.
  - `id_p` is unused.

## Test plan
- Basic serialize: W=32, digest words 0x11111111 (bits [255:224]) through 0x88888888 (bits [31:0]), `yumi_i` held 1 → `v_o` high for 8 consecutive cycles starting the cycle after accept; outputs 0x11111111..0x88888888 in order; `ready_o` returns to 1 after the 8th `yumi_i`.
- Backpressure: same digest, `yumi_i` toggling 1,0,0,1,… → each word held stable while `yumi_i`=0; no word is skipped or duplicated; 8 words total.
- Back-to-back: `v_i` held high with digest B during transfer of digest A → B is not accepted until IDLE; B's first word appears 2 cycles after A's last `yumi_i`; A's words are uncorrupted.
- Reset mid-transfer: assert `reset_i` after word 3 → next cycle `v_o`=0 and `data_o`=0; after release `ready_o`=1; a new digest is serialized from word 0.
- Enable freeze: drop `en_i` for 5 cycles in SEND at `cnt`=4 while `yumi_i`=1 → `v_o`=0 and no advance; after `en_i` rises, word 4 (0x55555555) is presented.
- Header (macro defined, `id_p`=5, W=32) → first word 0x00000508, then 0x11111111..0x88888888; 9 words total.
